// File: rtl/bubble_collapse_stream.sv
// Streaming bubble-collapse shifter: packs kept lanes toward lane 0 in order, zero-fills the rest.
// One prefix stage followed by log2(LANES) collapse stages under a global stall.
module bubble_collapse_stream #(
  parameter int unsigned LANES         = 32,
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned DIST_WIDTH    = 7,
  parameter int unsigned MAX_LIFM_RSIZ = 3
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_bypass,
  input  logic [LANES-1:0]                            in_mask,
  input  logic [LANES*WORD_WIDTH-1:0]                 in_lifm,
  input  logic [LANES*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   in_mt,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [LANES*WORD_WIDTH-1:0]                 out_lifm,
  output logic [LANES*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   out_mt,
  output logic [LANES-1:0]                            out_mask,
  output logic [$clog2(LANES+1)-1:0]                  out_cnt
);

  localparam int unsigned S   = $clog2(LANES);
  localparam int unsigned CW  = $clog2(LANES + 1);
  localparam int unsigned MTW = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int unsigned LW  = LANES * WORD_WIDTH;
  localparam int unsigned MW  = LANES * MTW;
  localparam int unsigned SW  = LANES * S;

  // Index 0 is the prefix stage; index k+1 holds the result of collapse stage k.
  logic          v_q   [S+1];
  logic          v_d   [S+1];
  logic [LW-1:0] w_q   [S+1];
  logic [LW-1:0] w_d   [S+1];
  logic [MW-1:0] mt_q  [S+1];
  logic [MW-1:0] mt_d  [S+1];
  logic [SW-1:0] sh_q  [S+1];
  logic [SW-1:0] sh_d  [S+1];
  logic [LANES-1:0] lv_q [S+1];
  logic [LANES-1:0] lv_d [S+1];
  logic [CW-1:0] cnt_q [S+1];
  logic [CW-1:0] cnt_d [S+1];
  logic [S-1:0]  collision;
  logic          en;

  assign en       = !v_q[S] | out_ready;
  assign in_ready = en;

  always_comb begin
    int unsigned   zeros;
    int unsigned   ones;
    logic          keep;
    logic          mv;
    logic          stay;
    logic [LW-1:0]    w_up;
    logic [MW-1:0]    mt_up;
    logic [SW-1:0]    sh_up;
    logic [LANES-1:0] lv_up;

    zeros     = 0;
    ones      = 0;
    keep      = 1'b0;
    mv        = 1'b0;
    stay      = 1'b0;
    w_up      = '0;
    mt_up     = '0;
    sh_up     = '0;
    lv_up     = '0;
    collision = '0;

    v_d[0]  = in_valid;
    w_d[0]  = '0;
    mt_d[0] = '0;
    sh_d[0] = '0;
    lv_d[0] = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      keep     = in_bypass | in_mask[i];
      lv_d[0][i] = keep;
      if (keep) begin
        w_d[0][i*WORD_WIDTH +: WORD_WIDTH] = in_lifm[i*WORD_WIDTH +: WORD_WIDTH];
        mt_d[0][i*MTW +: MTW]              = in_mt[i*MTW +: MTW];
      end
      if (!in_bypass) sh_d[0][i*S +: S] = S'(zeros);
      if (in_mask[i]) ones = ones + 1;
      else            zeros = zeros + 1;
    end
    cnt_d[0] = in_bypass ? CW'(LANES) : CW'(ones);

    for (int k = 0; k < int'(S); k++) begin
      // Lane j+2^k viewed at position j; zero-filled beyond the top lane.
      w_up  = w_q[k] >> (WORD_WIDTH << k);
      mt_up = mt_q[k] >> (MTW << k);
      sh_up = sh_q[k] >> (S << k);
      lv_up = lv_q[k] >> (1 << k);

      v_d[k+1]   = v_q[k];
      cnt_d[k+1] = cnt_q[k];
      w_d[k+1]   = '0;
      mt_d[k+1]  = '0;
      sh_d[k+1]  = '0;
      lv_d[k+1]  = '0;
      for (int j = 0; j < int'(LANES); j++) begin
        mv   = lv_up[j] & sh_up[j*S + k];
        stay = lv_q[k][j] & !sh_q[k][j*S + k];
        if (mv) begin
          w_d[k+1][j*WORD_WIDTH +: WORD_WIDTH] = w_up[j*WORD_WIDTH +: WORD_WIDTH];
          mt_d[k+1][j*MTW +: MTW]              = mt_up[j*MTW +: MTW];
          sh_d[k+1][j*S +: S]                  = sh_up[j*S +: S];
          lv_d[k+1][j]                         = 1'b1;
        end else if (stay) begin
          w_d[k+1][j*WORD_WIDTH +: WORD_WIDTH] = w_q[k][j*WORD_WIDTH +: WORD_WIDTH];
          mt_d[k+1][j*MTW +: MTW]              = mt_q[k][j*MTW +: MTW];
          sh_d[k+1][j*S +: S]                  = sh_q[k][j*S +: S];
          lv_d[k+1][j]                         = 1'b1;
        end
        if (mv && stay) collision[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= int'(S); s++) begin
        v_q[s]   <= 1'b0;
        w_q[s]   <= '0;
        mt_q[s]  <= '0;
        sh_q[s]  <= '0;
        lv_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else if (en) begin
      assert (collision == '0);
      for (int s = 0; s <= int'(S); s++) begin
        v_q[s]   <= v_d[s];
        w_q[s]   <= w_d[s];
        mt_q[s]  <= mt_d[s];
        sh_q[s]  <= sh_d[s];
        lv_q[s]  <= lv_d[s];
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  assign out_valid = v_q[S];
  assign out_lifm  = w_q[S];
  assign out_mt    = mt_q[S];
  assign out_cnt   = cnt_q[S];

  always_comb begin
    out_mask = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      out_mask[j] = (CW'(j) < cnt_q[S]);
    end
  end

endmodule

// File: tb/tb_bubble_collapse_stream.sv
// Directed and randomized checks for bubble_collapse_stream at LANES=32.
module tb_bubble_collapse_stream;

  localparam int LANES = 32;
  localparam int WW    = 8;
  localparam int MTW   = 21;
  localparam int CW    = 6;
  localparam int LW    = LANES * WW;
  localparam int MW    = LANES * MTW;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_bypass;
  logic [LANES-1:0] in_mask;
  logic [LW-1:0]    in_lifm;
  logic [MW-1:0]    in_mt;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    out_lifm;
  logic [MW-1:0]    out_mt;
  logic [LANES-1:0] out_mask;
  logic [CW-1:0]    out_cnt;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0]    id_l, el;
  logic [MW-1:0]    id_m, em;
  logic [CW-1:0]    ec;
  logic [LANES-1:0] ek;

  bubble_collapse_stream #(
    .LANES        (LANES),
    .WORD_WIDTH   (WW),
    .DIST_WIDTH   (7),
    .MAX_LIFM_RSIZ(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bypass(in_bypass),
    .in_mask  (in_mask),
    .in_lifm  (in_lifm),
    .in_mt    (in_mt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lifm (out_lifm),
    .out_mt   (out_mt),
    .out_mask (out_mask),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk lanes in order, append each kept one.
  function automatic void model(input logic [LANES-1:0] m, input logic bp,
                                input logic [LW-1:0] l, input logic [MW-1:0] t,
                                output logic [LW-1:0] ol, output logic [MW-1:0] om,
                                output logic [CW-1:0] oc, output logic [LANES-1:0] ok);
    int j;
    j  = 0;
    ol = '0;
    om = '0;
    ok = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bp || m[i]) begin
        ol[j*WW +: WW]   = l[i*WW +: WW];
        om[j*MTW +: MTW] = t[i*MTW +: MTW];
        j++;
      end
    end
    oc = CW'(j);
    for (int i = 0; i < LANES; i++) ok[i] = (i < j);
  endfunction

  task automatic set_line(input logic [LANES-1:0] m, input logic bp);
    in_lifm   = id_l;
    in_mt     = id_m;
    in_mask   = m;
    in_bypass = bp;
    in_valid  = 1'b1;
  endtask

  task automatic rand_line();
    int sel;
    for (int i = 0; i < LW / 32; i++) in_lifm[i*32 +: 32] = $urandom;
    for (int i = 0; i < MW / 32; i++) in_mt[i*32 +: 32] = $urandom;
    sel = $urandom_range(0, 7);
    in_mask   = (sel == 0) ? '0 : (sel == 1) ? '1 : LANES'($urandom);
    in_bypass = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_lifm"}, out_lifm, el);
    chk({tag, "_mt"}, out_mt, em);
    chk({tag, "_cnt"}, out_cnt, ec);
    chk({tag, "_mask"}, out_mask, ek);
  endtask

  // Streams n lines; rnd=0 uses ready pattern 1,0,0,1, rnd=1 random ready.
  task automatic stream(input int n, input bit rnd);
    logic [LW-1:0]    ql[$];
    logic [MW-1:0]    qm[$];
    logic [CW-1:0]    qc[$];
    logic [LANES-1:0] qk[$];
    logic [LW-1:0]    tl;
    logic [MW-1:0]    tm;
    logic [CW-1:0]    tc;
    logic [LANES-1:0] tk;
    int sent, got;
    bit acc;
    sent = 0;
    got  = 0;
    rand_line();
    for (int cyc = 0; cyc < 1000 && got < n; cyc++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid  = (sent < n);
      #1;
      acc = 1'b0;
      if (out_valid) begin
        if (ql.size() == 0) begin
          chk("stream_extra", 32'(got + 1), 32'(sent));
        end else begin
          // Held while stalled: must still show the oldest unconsumed line.
          chk("stream_lifm", out_lifm, ql[0]);
          chk("stream_mt", out_mt, qm[0]);
          chk("stream_cnt", out_cnt, qc[0]);
          chk("stream_mask", out_mask, qk[0]);
          if (out_ready) begin
            void'(ql.pop_front());
            void'(qm.pop_front());
            void'(qc.pop_front());
            void'(qk.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_mask, in_bypass, in_lifm, in_mt, tl, tm, tc, tk);
        ql.push_back(tl);
        qm.push_back(tm);
        qc.push_back(tc);
        qk.push_back(tk);
        sent++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) rand_line();
    end
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, n);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) begin
      id_l[i*WW +: WW]   = WW'(i);
      id_m[i*MTW +: MTW] = MTW'(i);
    end
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    in_mask   = '0;
    in_lifm   = '0;
    in_mt     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_lifm", out_lifm, '0);
    chk("rst_mt", out_mt, '0);
    chk("rst_cnt", out_cnt, '0);
    chk("rst_mask", out_mask, '0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    // Basic compaction, mask F0: lanes 4..7 land in 0..3 after 6 cycles.
    set_line(32'h0000_00F0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("basic_early", out_valid, 1'b0);
    tick();
    el = '0;
    el[31:0] = 32'h0706_0504;
    em = '0;
    for (int j = 0; j < 4; j++) em[j*MTW +: MTW] = MTW'(j + 4);
    ec = 6'd4;
    ek = 32'h0000_000F;
    check_line("basic");
    tick();
    chk("basic_single", out_valid, 1'b0);

    // Edge masks back to back.
    set_line(32'h0000_0000, 1'b0);
    tick();
    set_line(32'hFFFF_FFFF, 1'b0);
    tick();
    set_line(32'h8000_0000, 1'b0);
    tick();
    set_line(32'h5555_5555, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    el = '0;
    em = '0;
    ec = 6'd0;
    ek = '0;
    check_line("zero");
    tick();
    el = id_l;
    em = id_m;
    ec = 6'd32;
    ek = '1;
    check_line("ones");
    tick();
    el = '0;
    el[7:0] = 8'd31;
    em = '0;
    em[MTW-1:0] = MTW'(31);
    ec = 6'd1;
    ek = 32'h1;
    check_line("top");
    tick();
    el = '0;
    em = '0;
    for (int j = 0; j < 16; j++) begin
      el[j*WW +: WW]   = WW'(2 * j);
      em[j*MTW +: MTW] = MTW'(2 * j);
    end
    ec = 6'd16;
    ek = 32'h0000_FFFF;
    check_line("alt");
    tick();
    chk("edge_end", out_valid, 1'b0);

    // Bypass keeps every lane regardless of mask.
    set_line(32'h0000_0001, 1'b1);
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    el = id_l;
    em = id_m;
    ec = 6'd32;
    ek = '1;
    check_line("bypass");
    tick();

    stream(10, 1'b0);

    // Reset with three lines in flight; a line presented during reset is dropped too.
    set_line(32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_lifm", out_lifm, '0);
    chk("midrst_mt", out_mt, '0);
    chk("midrst_cnt", out_cnt, '0);
    chk("midrst_mask", out_mask, '0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("midrst_drop", out_valid, 1'b0);
    end
    set_line(32'h0F0F_0F0F, 1'b0);
    model(in_mask, 1'b0, id_l, id_m, el, em, ec, ek);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_lat_early", out_valid, 1'b0);
    tick();
    check_line("midrst_lat");
    tick();

    stream(40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bubble_collapse_stream.md
# bubble_collapse_stream

Pipelined, parametrised bubble-collapsing shifter for the redundancy controller datapath. Each accepted line carries LANES lifm words, their mapping-table (mt) entries and a keep mask. The block packs kept lanes toward lane 0 in original order and zero-fills the vacated lanes. It streams one line per cycle through a valid/ready interface, sitting between the psum/mask generator and the compressed-line buffer.

## Interface
- LANES, 32: lanes per line; must be a power of two, ≥2.
- WORD_WIDTH, 8: bits per lifm word.
- DIST_WIDTH, 7: bits per mt distance field.
- MAX_LIFM_RSIZ, 3: mt fields per lane; mt lane width MTW = DIST_WIDTH*MAX_LIFM_RSIZ.
- Derived: S = $clog2(LANES); CW = $clog2(LANES+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input line valid.
- in_ready  out  1  block can accept a line this cycle.
- in_bypass  in  1  1 = pass the line uncompacted.
- in_mask  in  LANES  bit i = 1 keeps lane i.
- in_lifm  in  LANES*WORD_WIDTH  lane i at [i*WORD_WIDTH +: WORD_WIDTH].
- in_mt  in  LANES*MTW  lane i at [i*MTW +: MTW].
- out_valid  out  1  output line valid.
- out_ready  in  1  downstream accepts.
- out_lifm  out  LANES*WORD_WIDTH  compacted words.
- out_mt  out  LANES*MTW  compacted mt entries, moved with their words.
- out_mask  out  LANES  thermometer: bits [out_cnt-1:0] = 1.
- out_cnt  out  CW  number of kept lanes, 0..LANES.

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Stage P (prefix):
  - Registers the line.
  - For each lane i, computes shift amount sh[i] = count of zero mask bits in lanes 0..i-1 (width S).
  - Computes cnt = popcount(in_mask).
  - Clears the lifm/mt of masked-off lanes to 0 and marks those lanes invalid.
- Bypass: sh[i] = 0 for all lanes, all lanes treated as kept, cnt = LANES.
- Stages C0..C(S-1) (collapse, LSB first):
  - In stage k, a valid lane i with bit k of its sh set moves to lane i-2^k, carrying word, mt, remaining sh and valid flag.
  - Otherwise the lane stays in place.
  - This ordering is collision-free. Any destination receiving two valid lanes is a design error; the assertion must never fire.
- Output:
  - Lane j < cnt holds the j-th kept input lane in ascending index order.
  - Lanes ≥ cnt are 0 in both out_lifm and out_mt.
  - out_mask = (1<<cnt)-1, with LANES-bit wrap: cnt = LANES gives all ones.
- Flow control is global stall: en = !out_valid | out_ready, and in_ready = en.
  - When en = 0, every stage, including its valid bit, holds.
  - A stalled pipeline does not squeeze internal empty slots.
- Boundaries:
  - mask all-zero: cnt = 0, all outputs 0, out_valid still asserted.
  - mask all-one: line unchanged, cnt = LANES.
  - mask = 1 in lane LANES-1 only: the word lands in lane 0.
- Reset:
  - All stage valid bits and data registers clear to 0.
  - In-flight lines are discarded, not flushed.
  - in_ready = 1 from the first cycle after reset deasserts.

## Timing
- Latency L = 1 + S cycles (6 for LANES=32): a line accepted at edge t shows out_valid = 1 after edge t+L-1, absent stalls.
- Throughput is one line/cycle when out_ready = 1; up to L lines in flight.
- out_* are registered; no combinational path from in_* to out_*. in_ready depends combinationally only on out_ready and out_valid.
- out_lifm, out_mt, out_mask and out_cnt stay stable while out_valid & !out_ready.
- Reset values: out_valid = 0, out_lifm = 0, out_mt = 0, out_mask = 0, out_cnt = 0.
- in_ready is 1 during reset (en = 1), but inputs sampled during reset are dropped.

## Test plan
- Basic compaction, LANES=32, lifm lane i = i, mt lane i = i, mask = 32'h0000_00F0, out_ready = 1:
  - 6 cycles later: lanes 0..3 = 4,5,6,7; other lanes 0.
  - out_cnt = 4, out_mask = 32'hF.
- Edge masks, back-to-back lines 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5555_5555:
  - out_cnt = 0, 32, 1, 16.
  - Third line: lane 0 = 31.
  - Fourth line: lanes 0..15 = 0,2,...,30.
  - Four consecutive out_valid cycles.
- Bypass: in_bypass = 1, mask = 32'h1 → output equals input, out_cnt = 32, out_mask = all ones.
- Backpressure: stream 10 lines with out_ready toggling 1,0,0,1 → no loss or duplication, outputs held while stalled, order preserved; check against a reference model.
- Reset mid-stream: 3 lines in flight, reset high for 1 cycle → out_valid = 0 and all outputs 0 next cycle; in-flight lines never appear; the next line accepted has latency 6.
- Random regression:
  - LANES = 8, 16, 32 with random masks, data and ready; compare to scoreboard.
  - Collision assertion never fires.
